vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Parametrised VRAM access arbiter between one 8-bit read/write host port and NUM_RD 32-bit read-only fetch ports, driving one external single-port 32-bit RAM with one-cycle read latency (e.g. main_ram_generic). It replaces fixed four-port arbitration with a configurable port count and address width. It adds same-cycle grant outputs, round-robin fairness among fetch ports, and a bounded host-burst limit so fetch ports cannot starve. It sits between the host register interface and the layer/sprite fetch engines.

## Interface
- ADDR_W, 15: RAM word-address width; host byte address is ADDR_W+2 bits.
- NUM_RD, 3: number of 32-bit read ports, 1..8.
- HOST_MAX_RUN, 4: maximum consecutive host grants while any fetch request is pending, 1..15.

Ports (clock and reset first):
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- hst_addr  in  ADDR_W+2  host byte address.
- hst_wrdata  in  8  host write byte.
- hst_write  in  1  1 = write, 0 = read; qualified by hst_strobe.
- hst_strobe  in  1  host request, held until granted.
- hst_gnt  out  1  combinational; host is granted this cycle.
- hst_ack  out  1  registered; high the cycle after a host grant.
- hst_rddata  out  8  host read byte; valid while hst_ack, then held.
- rd_addr  in  NUM_RD*ADDR_W  packed word addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_strobe  in  NUM_RD  per-port request, held until granted.
- rd_gnt  out  NUM_RD  combinational one-hot grant.
- rd_ack  out  NUM_RD  registered; bit i high the cycle after port i is granted.
- rd_rddata  out  32  shared read data; valid for the port whose rd_ack bit is high.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wrdata  out  32  hst_wrdata replicated ×4.
- ram_wrbytesel  out  4  one-hot lane from hst_addr[1:0] (00→0001 … 11→1000).
- ram_write  out  1  hst_gnt && hst_write.
- ram_rddata  in  32  RAM read data, one cycle after address.

## Operation
- Request/grant handshake: a request is strobe high in a cycle. At most one grant is issued per cycle, and it is combinational in that cycle. The requester deasserts strobe, or presents its next request, in the following cycle. Ungranted requesters hold strobe and address stable.
- Default priority: host over fetch ports.
- Starvation guard: host_run counter, 4 bits.
  - Increments on each host grant made while any rd_strobe is high.
  - Clears on any fetch grant, and in any cycle with no fetch request pending.
  - When host_run == HOST_MAX_RUN and any rd_strobe is high, the fetch arbiter is granted instead of the host, and host_run clears.
- Fetch selection: see Configuration. Round-robin pointer rr_ptr is stored as log2 NUM_RD bits.
- No grant: ram_addr = 0, ram_write = 0.
- Host read path:
  - Byte lane hst_addr[1:0] is registered at grant.
  - hst_rddata selects that byte from ram_rddata while hst_ack is high, and loads a hold register.
  - Otherwise hst_rddata outputs the hold register.
- Host write: the RAM write occurs in the grant cycle. hst_ack still pulses the next cycle, and hst_rddata shows the pre-write byte of the addressed word.

## Timing
- Grant to ack/data latency: exactly 1 cycle, for every port.
- Throughput: one access per cycle, back-to-back across any ports. A single port may be granted on consecutive cycles.
- Reset (while rst high and the cycle after):
  - hst_ack = 0, rd_ack = 0, hst_rddata hold = 0, host_run = 0, rr_ptr = 0.
  - All gnt outputs and ram_write are forced to 0 while rst is high.
- Reset mid-access: an access granted in the cycle before rst rises produces no ack. A write in a cycle with rst high is suppressed.
- Simultaneous host and all fetch strobes at host_run < HOST_MAX_RUN: host wins.
- Counter boundary: HOST_MAX_RUN = 1 alternates host and fetch under full contention.
- rr_ptr wrap: after port NUM_RD-1 is granted, the pointer returns to 0.

## Configuration
- VRAM_ARB_RR_EN defined:
  - Fetch ports are arbitrated round-robin. The search starts at rr_ptr; after granting port i, rr_ptr = (i+1) mod NUM_RD.
  - rr_ptr advances only on fetch grants.
- Not defined:
  - Fixed priority: lowest-index requesting fetch port wins.
  - rr_ptr logic is removed.
- The host priority and starvation guard are present in both builds.

## Test plan
- Host write 0xA5 to byte address 0x00006, then host read of the same address → ram_wrbytesel = 0100 in the write grant cycle; read hst_ack next cycle with hst_rddata = 0xA5, held after ack drops.
- All three fetch ports strobing continuously, no host, VRAM_ARB_RR_EN → grants 0,1,2,0,1,2…; each rd_ack one cycle after its grant, with rd_rddata equal to RAM content at that port's address.
- Same stimulus without VRAM_ARB_RR_EN → port 0 granted every cycle; ports 1 and 2 are never granted.
- Host strobe continuous plus port 1 strobe, HOST_MAX_RUN = 4 → pattern H,H,H,H,R1 repeating.
- rst asserted in the cycle after a fetch grant → no rd_ack; all acks 0, rr_ptr 0; first post-reset grant goes to port 0.
- Host write and fetch requests in the same cycle as rst high → ram_write = 0, all gnt outputs 0; memory contents unchanged on readback.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM access arbiter: one 8-bit host port plus NUM_RD 32-bit fetch ports onto one
// single-port RAM with 1-cycle read latency. Define VRAM_ARB_RR_EN for round-robin fetch arbitration.
module vram_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int NUM_RD       = 3,
  parameter int HOST_MAX_RUN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+1:0]        hst_addr,
  input  logic [7:0]               hst_wrdata,
  input  logic                     hst_write,
  input  logic                     hst_strobe,
  output logic                     hst_gnt,
  output logic                     hst_ack,
  output logic [7:0]               hst_rddata,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_strobe,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [NUM_RD-1:0]        rd_ack,
  output logic [31:0]              rd_rddata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [31:0]              ram_wrdata,
  output logic [3:0]               ram_wrbytesel,
  output logic                     ram_write,
  input  logic [31:0]              ram_rddata
);

  // Handshake: a requester holds strobe (and its address/data) until it sees its gnt
  // high in the same cycle; the access is then complete and ack/data follow one cycle later.

  localparam int         SEL_W     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam logic [3:0] RUN_LIMIT = 4'(HOST_MAX_RUN);

  logic              any_rd;
  logic              host_win;
  logic              fetch_win;
  logic [SEL_W-1:0]  fetch_sel;
  logic [ADDR_W-1:0] fetch_addr;
  logic [3:0]        host_run;
  logic              hst_ack_q;
  logic [NUM_RD-1:0] rd_ack_q;
  logic [1:0]        hst_lane;
  logic [7:0]        hst_hold;
  logic [7:0]        lane_byte;

  assign any_rd = |rd_strobe;

  // The host loses one slot only once it has used up its run while a fetch is waiting.
  assign host_win  = !rst && hst_strobe && !(any_rd && (host_run == RUN_LIMIT));
  assign fetch_win = !rst && any_rd && !host_win;

`ifdef VRAM_ARB_RR_EN
  logic [SEL_W-1:0] rr_ptr;

  always_comb begin
    logic found;
    int   idx;
    found      = 1'b0;
    idx        = 0;
    fetch_sel  = '0;
    fetch_addr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_RD;
      if (!found && rd_strobe[idx]) begin
        found      = 1'b1;
        fetch_sel  = SEL_W'(idx);
        fetch_addr = rd_addr[idx*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (fetch_win) begin
      rr_ptr <= SEL_W'((int'(fetch_sel) + 1) % NUM_RD);
    end
  end
`else
  always_comb begin
    logic found;
    found      = 1'b0;
    fetch_sel  = '0;
    fetch_addr = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!found && rd_strobe[k]) begin
        found      = 1'b1;
        fetch_sel  = SEL_W'(k);
        fetch_addr = rd_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end
`endif

  assign hst_gnt = host_win;

  always_comb begin
    rd_gnt = '0;
    if (fetch_win) rd_gnt[fetch_sel] = 1'b1;
  end

  always_comb begin
    ram_addr = '0;
    if (host_win) begin
      ram_addr = hst_addr[ADDR_W+1:2];
    end else if (fetch_win) begin
      ram_addr = fetch_addr;
    end
  end

  assign ram_write     = host_win && hst_write;
  assign ram_wrdata    = {4{hst_wrdata}};
  assign ram_wrbytesel = 4'b0001 << hst_addr[1:0];

  assign lane_byte = ram_rddata[{hst_lane, 3'b000} +: 8];

  // Acks are masked while rst is high so an access granted just before reset never completes.
  assign hst_ack    = hst_ack_q && !rst;
  assign rd_ack     = rd_ack_q & {NUM_RD{!rst}};
  assign rd_rddata  = ram_rddata;
  assign hst_rddata = rst ? 8'h00 : (hst_ack_q ? lane_byte : hst_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      hst_ack_q <= 1'b0;
      rd_ack_q  <= '0;
      hst_lane  <= 2'b00;
      hst_hold  <= 8'h00;
      host_run  <= 4'd0;
    end else begin
      hst_ack_q <= host_win;
      rd_ack_q  <= rd_gnt;
      if (host_win) hst_lane <= hst_addr[1:0];
      if (hst_ack_q) hst_hold <= lane_byte;
      if (fetch_win || !any_rd) begin
        host_run <= 4'd0;
      end else if (host_win) begin
        host_run <= host_run + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized scoreboard bench for vram_arbiter with a behavioural RAM and arbitration model.
module tb_vram_arbiter;
  localparam int ADDR_W       = 15;
  localparam int NUM_RD       = 3;
  localparam int HOST_MAX_RUN = 4;
  localparam int W            = 37;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W+1:0] addr;
    logic [7:0]        data;
  } hcmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [ADDR_W+1:0]        hst_addr = '0;
  logic [7:0]               hst_wrdata = '0;
  logic                     hst_write = 1'b0;
  logic                     hst_strobe = 1'b0;
  logic                     hst_gnt;
  logic                     hst_ack;
  logic [7:0]               hst_rddata;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD-1:0]        rd_strobe = '0;
  logic [NUM_RD-1:0]        rd_gnt;
  logic [NUM_RD-1:0]        rd_ack;
  logic [31:0]              rd_rddata;
  logic [ADDR_W-1:0]        ram_addr;
  logic [31:0]              ram_wrdata;
  logic [3:0]               ram_wrbytesel;
  logic                     ram_write;
  logic [31:0]              ram_rddata;

  vram_arbiter #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .HOST_MAX_RUN(HOST_MAX_RUN)) dut (
    .clk(clk), .rst(rst),
    .hst_addr(hst_addr), .hst_wrdata(hst_wrdata), .hst_write(hst_write),
    .hst_strobe(hst_strobe), .hst_gnt(hst_gnt), .hst_ack(hst_ack), .hst_rddata(hst_rddata),
    .rd_addr(rd_addr), .rd_strobe(rd_strobe), .rd_gnt(rd_gnt), .rd_ack(rd_ack),
    .rd_rddata(rd_rddata), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
    .ram_wrbytesel(ram_wrbytesel), .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  // ---------------- helpers ----------------
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i + 1) * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge_word(logic [31:0] old, logic [31:0] wd, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic int onehot_idx(logic [NUM_RD-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_RD; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic hcmd_t rand_cmd();
    hcmd_t c;
    c.wr        = 1'($urandom_range(0, 1));
    c.addr      = '0;
    c.addr[5:0] = 6'($urandom_range(0, 63));
    c.data      = 8'($urandom);
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external RAM (read-first, 16 words populated) ----------------
  logic [31:0] ram [16];
  logic        ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
      ram_rddata <= '0;
    end else begin
      ram_rddata <= ram[ram_addr[3:0]];
      if (ram_write) ram[ram_addr[3:0]] <= merge_word(ram[ram_addr[3:0]], ram_wrdata, ram_wrbytesel);
    end
  end

  // ---------------- stimulus state ----------------
  hcmd_t             host_q[$];
  int                host_mode = 0;     // 0 queue only, 1 random, 2 continuous
  int                rd_mode [NUM_RD];  // 0 off, 1 continuous, 2 random
  logic              rst_next = 1'b1;
  logic              model_hst_g = 1'b0;
  logic [NUM_RD-1:0] model_rd_g = '0;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           gnt_log[$];
  logic [31:0]  ref_mem [16];
  logic [7:0]   exp_hold = 8'h00;
  logic [7:0]   last_hst_data = 8'h00;
  int           m_run = 0;
  int           m_rr = 0;

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_next;
    if (model_hst_g && host_q.size() > 0) void'(host_q.pop_front());
    if (host_mode == 2 && host_q.size() == 0) host_q.push_back(rand_cmd());
    if (host_mode == 1 && host_q.size() == 0 && $urandom_range(0, 2) == 0) host_q.push_back(rand_cmd());
    if (host_q.size() > 0) begin
      hst_strobe = 1'b1;
      hst_write  = host_q[0].wr;
      hst_addr   = host_q[0].addr;
      hst_wrdata = host_q[0].data;
    end else begin
      hst_strobe = 1'b0;
      hst_write  = 1'($urandom_range(0, 1));
      hst_addr   = '0;
      hst_wrdata = 8'($urandom);
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_mode[i] == 0) begin
        rd_strobe[i] = 1'b0;
      end else if (model_rd_g[i] || !rd_strobe[i]) begin
        rd_strobe[i] = (rd_mode[i] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic sync_clear_log();
    @(negedge clk);
    #2;
    gnt_log.delete();
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  // ---------------- reference model: predicts grants, pushes expected acks ----------------
  always begin : model
    logic              any;
    logic              eh;
    logic [NUM_RD-1:0] er;
    int                p;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       word;
    logic [7:0]        b;
    @(negedge clk);
    #1;
    any  = |rd_strobe;
    eh   = 1'b0;
    er   = '0;
    p    = -1;
    ea   = '0;
    if (rst) begin
      m_run = 0;
      m_rr  = 0;
    end else begin
      if (hst_strobe && !(any && m_run == HOST_MAX_RUN)) begin
        eh = 1'b1;
      end else if (any) begin
`ifdef VRAM_ARB_RR_EN
        for (int k = 0; k < NUM_RD; k++)
          if (p < 0 && rd_strobe[(m_rr + k) % NUM_RD]) p = (m_rr + k) % NUM_RD;
`else
        for (int k = 0; k < NUM_RD; k++)
          if (p < 0 && rd_strobe[k]) p = k;
`endif
        er[p] = 1'b1;
        m_rr  = (p + 1) % NUM_RD;
      end
      if (er != '0 || !any) m_run = 0;
      else if (eh) m_run = m_run + 1;
    end
    if (eh) ea = hst_addr[ADDR_W+1:2];
    else if (er != '0) ea = rd_addr[p*ADDR_W +: ADDR_W];

    check("hst_gnt", hst_gnt, eh);
    check("rd_gnt", rd_gnt, er);
    check("ram_write", ram_write, eh && hst_write);
    check("ram_addr", ram_addr, ea);
    if (eh && hst_write) begin
      check("ram_wrbytesel", ram_wrbytesel, 4'b0001 << hst_addr[1:0]);
      check("ram_wrdata", ram_wrdata, {4{hst_wrdata}});
    end

    if (eh) begin
      word = ref_mem[ea[3:0]];
      b    = word[8*hst_addr[1:0] +: 8];
      exp_q.push_back({1'b1, 4'd0, 24'd0, b});
      if (hst_write) ref_mem[ea[3:0]] = merge_word(word, {4{hst_wrdata}}, 4'b0001 << hst_addr[1:0]);
    end else if (er != '0) begin
      exp_q.push_back({1'b0, 4'(p), ref_mem[ea[3:0]]});
    end

    gnt_log.push_back(hst_gnt ? 1 : ((rd_gnt != '0) ? 2 + onehot_idx(rd_gnt) : 0));
    model_hst_g = eh;
    model_rd_g  = er;
  end

  // ---------------- monitor: pops expected responses when acks appear ----------------
  always begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] a;
    @(negedge clk);
    if (rst) begin
      check("ack_in_reset", {hst_ack, rd_ack}, '0);
      check("rddata_in_reset", hst_rddata, 8'h00);
      exp_q.delete();
      exp_hold = 8'h00;
    end else if (hst_ack || rd_ack != '0) begin
      check("ack_onehot", 32'($countones(rd_ack)) + 32'(hst_ack), 1);
      if (hst_ack) a = {1'b1, 4'd0, 24'd0, hst_rddata};
      else         a = {1'b0, 4'(onehot_idx(rd_ack)), rd_rddata};
      check("ack_queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_data", a, e);
        if (hst_ack) begin
          exp_hold      = e[7:0];
          last_hst_data = hst_rddata;
        end
      end
    end else begin
      check("missing_ack", exp_q.size(), 0);
      exp_q.delete();
      check("hst_rddata_hold", hst_rddata, exp_hold);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] pre_byte;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < NUM_RD; i++) rd_mode[i] = 0;

    repeat (3) step();
    rst_next = 1'b0;
    step();

    // host write 0xA5 to byte 0x00006, then read it back
    host_q.push_back('{wr: 1'b1, addr: 17'h00006, data: 8'hA5});
    host_q.push_back('{wr: 1'b0, addr: 17'h00006, data: 8'h00});
    for (int t = 0; t < 20 && host_q.size() > 0; t++) step();
    check("host_drain_a5", host_q.size(), 0);
    repeat (3) step();
    check("a5_read_data", last_hst_data, 8'hA5);
    settle();
    check("a5_hold", hst_rddata, 8'hA5);

    // all fetch ports continuous from reset
    rst_next = 1'b1;
    repeat (2) step();
    rst_next = 1'b0;
    for (int i = 0; i < NUM_RD; i++) rd_mode[i] = 1;
    sync_clear_log();
    repeat (6) step();
    settle();
    check("fetch_log_len", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
`ifdef VRAM_ARB_RR_EN
      check($sformatf("fetch_seq_%0d", i), gnt_log[i], 2 + (i % 3));
`else
      check($sformatf("fetch_seq_%0d", i), gnt_log[i], 2);
`endif
    end

    // host continuous plus port 1: H,H,H,H,R1 repeating
    rd_mode[0] = 0;
    rd_mode[2] = 0;
    host_mode  = 2;
    sync_clear_log();
    repeat (10) step();
    settle();
    check("starve_log_len", gnt_log.size(), 10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      check($sformatf("starve_seq_%0d", i), gnt_log[i], (i % 5 == 4) ? 3 : 1);

    // reset in the cycle after a fetch grant
    host_mode = 0;
    host_q.delete();
    for (int i = 0; i < NUM_RD; i++) rd_mode[i] = 1;
    step();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    sync_clear_log();
    step();
    settle();
    check("post_reset_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);

    // host write and fetches while rst is high: no access, memory untouched
    pre_byte = ref_mem[9][15:8];
    rst_next = 1'b1;
    host_q.push_back('{wr: 1'b1, addr: 17'h00025, data: 8'h3C});
    step();
    host_q.delete();
    for (int i = 0; i < NUM_RD; i++) rd_mode[i] = 0;
    rst_next = 1'b0;
    step();
    host_q.push_back('{wr: 1'b0, addr: 17'h00025, data: 8'h00});
    for (int t = 0; t < 20 && host_q.size() > 0; t++) step();
    check("host_drain_rst", host_q.size(), 0);
    repeat (2) step();
    check("rst_write_suppressed", last_hst_data, pre_byte);

    // randomized contention
    host_mode = 1;
    for (int i = 0; i < NUM_RD; i++) rd_mode[i] = 2;
    repeat (600) step();

    host_mode = 0;
    for (int t = 0; t < 40 && host_q.size() > 0; t++) step();
    check("host_drain_final", host_q.size(), 0);
    for (int i = 0; i < NUM_RD; i++) rd_mode[i] = 0;
    repeat (4) step();
    settle();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
